// File: rtl/sub_wide_seq_pkg.sv
// Shared types and constants for the multi-cycle wide subtractor sequencer.
package sub_wide_seq_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_wide_seq_if.sv
// Operand/result handshake bundle for sub_wide_seq; slave is the sequencer side.
interface sub_wide_seq_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, busy
  );
endinterface

// File: rtl/subtractor_32bit.sv
// Combinational 32-bit subtract slice: D = A - B - Bin, Bout set on unsigned underflow.
module subtractor_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Bin,
  output logic [31:0] D,
  output logic        Bout
);
  logic [32:0] w_diff;

  // One guard bit above the word catches the underflow as the borrow.
  always_comb begin
    w_diff = {1'b0, A} - {1'b0, B} - {32'b0, Bin};
    D      = w_diff[31:0];
    Bout   = w_diff[32];
  end
endmodule

// File: rtl/sub_wide_seq.sv
// Wide subtractor that reuses one 32-bit slice over WIDTH/32 cycles, LSW first.
module sub_wide_seq
  import sub_wide_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic           clk,
  input  logic           rst,
  sub_wide_seq_if.slave  bus
);
  localparam int unsigned NW    = WIDTH / WORD_W;
  localparam int unsigned IDX_W = $clog2(NW);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [WORD_W-1:0]  w_slice_d;
  logic               w_slice_bout;

  // Operand registers shift down one word per RUN cycle, so the slice always sees word 0.
  subtractor_32bit u_slice (
    .A    (r_a[WORD_W-1:0]),
    .B    (r_b[WORD_W-1:0]),
    .Bin  (r_borrow),
    .D    (w_slice_d),
    .Bout (w_slice_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_borrow    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_borrow   <= bus.bin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_d[WORD_W*int'(r_idx) +: WORD_W] <= w_slice_d;
          r_borrow <= w_slice_bout;
          r_a      <= r_a >> WORD_W;
          r_b      <= r_b >> WORD_W;
          if (r_idx == IDX_W'(NW - 1)) begin
            r_bout      <= w_slice_bout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_idx       <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.d         = r_d;
  assign bus.bout      = r_bout;
  assign bus.busy      = r_busy;

endmodule
